// File: rtl/full_adder_pipe_nbit.sv
// full_adder_pipe_nbit: WIDTH-bit adder split into STAGES equal slices; slice carry registered between stages.
// Latency: an operand accepted at edge n shows on Sum/Cout/Out_Valid after edge n+STAGES-1; one result per cycle.
// Backpressure: Out_Valid & ~Out_Ready freezes every stage and drops In_Ready in that same cycle.
// Optional build macro FULL_ADDER_SUB_EN adds port Sub: effective B = ~B and carry-in = Cin ^ Sub when Sub=1.
// WIDTH must be a multiple of STAGES; each stage adds one SW = WIDTH/STAGES bit slice.
module full_adder_pipe_nbit #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef FULL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Out_Valid,
    input  logic             Out_Ready
);

    localparam int SW = WIDTH / STAGES;

    logic             stall;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // The whole pipe freezes only when a finished result is refused downstream.
    assign stall    = Out_Valid & ~Out_Ready;
    assign In_Ready = ~stall;
    assign accept   = In_Valid & In_Ready;

`ifdef FULL_ADDER_SUB_EN
    // Subtraction is folded in at the entry: the inverted operand and adjusted
    // carry then travel down the pipe like any other add.
    assign b_eff   = Sub ? ~B : B;
    assign cin_eff = Cin ^ Sub;
`else
    assign b_eff   = B;
    assign cin_eff = Cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added from this stage upward.
        localparam int OPW = WIDTH - k * SW;

        logic [OPW-1:0]        a_in;
        logic [OPW-1:0]        b_in;
        logic                  c_in;
        logic                  vld_in;
        logic [SW:0]           slice_sum;
        logic [(k+1)*SW-1:0]   sum_d;
        logic [(k+1)*SW-1:0]   sum_q;
        logic                  cy_q;
        logic                  vld_q;

        if (k == 0) begin : g_head
            assign a_in   = A;
            assign b_in   = b_eff;
            assign c_in   = cin_eff;
            assign vld_in = accept;
            assign sum_d  = slice_sum[SW-1:0];
        end else begin : g_body
            assign a_in   = g_stage[k-1].g_fwd.a_q;
            assign b_in   = g_stage[k-1].g_fwd.b_q;
            assign c_in   = g_stage[k-1].cy_q;
            assign vld_in = g_stage[k-1].vld_q;
            // Finished lower slices pass through; this slice lands on top of them.
            assign sum_d  = {slice_sum[SW-1:0], g_stage[k-1].sum_q};
        end

        assign slice_sum = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

        // Stage result, slice carry and valid: advance together, hold on stall.
        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else if (!stall) begin
                vld_q <= vld_in;
                cy_q  <= slice_sum[SW];
                sum_q <= sum_d;
            end
        end

        // Upper operand bits not yet consumed; the last stage has none left.
        if (k < STAGES - 1) begin : g_fwd
            logic [OPW-SW-1:0] a_q;
            logic [OPW-SW-1:0] b_q;

            // Shift the unconsumed operand bits along with the partial sum.
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_in[OPW-1:SW];
                    b_q <= b_in[OPW-1:SW];
                end
            end
        end
    end

    assign Sum       = g_stage[STAGES-1].sum_q;
    assign Cout      = g_stage[STAGES-1].cy_q;
    assign Out_Valid = g_stage[STAGES-1].vld_q;

endmodule

// File: tb/tb_full_adder_pipe_nbit.sv
// tb_full_adder_pipe_nbit: random and directed stimulus against an arithmetic reference model.
// Latency: checks each result arrives STAGES cycles after acceptance plus any stall cycles.
// Backpressure: random and directed Out_Ready stalls, checking hold stability and In_Ready.
module tb_full_adder_pipe_nbit;

    localparam int W = 8;
    localparam int S = 2;

    logic         Clk = 1'b0;
    logic         Rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         In_Valid;
    logic         In_Ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Out_Valid;
    logic         Out_Ready;
    logic         sub_cur;
`ifdef FULL_ADDER_SUB_EN
    logic         Sub;
    assign sub_cur = Sub;
`else
    assign sub_cur = 1'b0;
`endif

    always #5 Clk = ~Clk;

    full_adder_pipe_nbit #(.WIDTH(W), .STAGES(S)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
`ifdef FULL_ADDER_SUB_EN
        .Sub       (Sub),
`endif
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready)
    );

    int n_vec  = 0;
    int n_miss = 0;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endfunction

    // {Cout,Sum} as plain integer arithmetic: A+B+Cin, or A-B-Cin offset by 2^W for subtract.
    function automatic logic [W:0] model(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
        longint r;
        if (sub) r = longint'(a) + (longint'(1) << W) - longint'(b) - longint'(cin);
        else     r = longint'(a) + longint'(b) + longint'(cin);
        return (W+1)'(r % (longint'(1) << (W + 1)));
    endfunction

    // Scoreboard: expected result, cycle it was accepted, stall count at that time.
    logic [W:0] exp_q[$];
    int         cyc_q[$];
    int         stl_q[$];
    int         cyc    = 0;
    int         stalls = 0;
    logic       prev_stall = 1'b0;
    logic [W:0] prev_out;

    always @(negedge Clk) begin
        logic [W:0] e;
        int c0, s0;
        cyc++;
        if (Rst) begin
            exp_q.delete();
            cyc_q.delete();
            stl_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", 64'(In_Ready), 64'(!(Out_Valid && !Out_Ready)));
            if (prev_stall) begin
                check("hold_valid", 64'(Out_Valid), 64'(1));
                check("hold_data", 64'({Cout, Sum}), 64'(prev_out));
            end
            if (Out_Valid && Out_Ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(Out_Valid), 64'(0));
                end else begin
                    e  = exp_q.pop_front();
                    c0 = cyc_q.pop_front();
                    s0 = stl_q.pop_front();
                    check("result", 64'({Cout, Sum}), 64'(e));
                    check("latency", 64'(cyc), 64'(c0 + S + (stalls - s0)));
                end
            end
            if (In_Valid && In_Ready) begin
                exp_q.push_back(model(A, B, Cin, sub_cur));
                cyc_q.push_back(cyc);
                stl_q.push_back(stalls);
            end
            prev_stall = Out_Valid && !Out_Ready;
            if (prev_stall) stalls++;
            prev_out = {Cout, Sum};
        end
    end

    task automatic rand_in();
        A   = W'($urandom);
        B   = W'($urandom);
        Cin = 1'($urandom_range(1));
`ifdef FULL_ADDER_SUB_EN
        Sub = 1'($urandom_range(1));
`endif
    endtask

    // One directed operand; called at posedge+1, checks literal result at the exact latency.
    task automatic do_one(string name, logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub,
                          logic [W:0] exp);
        Out_Ready = 1'b1;
        A = a; B = b; Cin = cin;
`ifdef FULL_ADDER_SUB_EN
        Sub = sub;
`endif
        In_Valid = 1'b1;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        repeat (S - 1) begin
            @(posedge Clk); #1;
        end
        check({name, "_valid"}, 64'(Out_Valid), 64'(1));
        check(name, 64'({Cout, Sum}), 64'(exp));
    endtask

    // Stream n operands, holding each until accepted; Out_Ready high with rdy_pct percent.
    task automatic stream(int n, int rdy_pct);
        int   sent  = 0;
        int   guard = 0;
        logic acc;
        Out_Ready = ($urandom_range(99) < rdy_pct);
        rand_in();
        In_Valid = 1'b1;
        while (sent < n && guard < 1000) begin
            @(negedge Clk);
            acc = In_Valid && In_Ready;
            @(posedge Clk); #1;
            guard++;
            if (acc) begin
                sent++;
                if (sent < n) rand_in();
                else In_Valid = 1'b0;
            end
            Out_Ready = ($urandom_range(99) < rdy_pct);
        end
        In_Valid = 1'b0;
        if (guard >= 1000) check("stream_timeout", 64'(sent), 64'(n));
    endtask

    task automatic drain();
        int guard = 0;
        Out_Ready = 1'b1;
        while ((exp_q.size() != 0 || Out_Valid) && guard < 50) begin
            @(posedge Clk); #1;
            guard++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        Rst = 1'b1; A = '0; B = '0; Cin = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
`ifdef FULL_ADDER_SUB_EN
        Sub = 1'b0;
`endif
        #1;
        check("rst_out_valid", 64'(Out_Valid), 64'(0));
        check("rst_sum", 64'(Sum), 64'(0));
        check("rst_cout", 64'(Cout), 64'(0));
        check("rst_in_ready", 64'(In_Ready), 64'(1));
        #22 Rst = 1'b0;
        @(posedge Clk); #1;

        do_one("basic", 8'h3C, 8'h05, 1'b0, 1'b0, 9'h041);
        do_one("slice_carry", 8'h0F, 8'h01, 1'b0, 1'b0, 9'h010);
        do_one("cin_ripple", 8'hFF, 8'h00, 1'b1, 1'b0, 9'h100);
        do_one("wrap", 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF);
`ifdef FULL_ADDER_SUB_EN
        do_one("sub_no_borrow", 8'h10, 8'h01, 1'b0, 1'b1, 9'h10F);
        do_one("sub_borrow", 8'h00, 8'h01, 1'b0, 1'b1, 9'h0FF);
`endif
        drain();

        // Back-to-back at full throughput.
        stream(16, 100);
        drain();

        // Directed backpressure: fill, refuse for 3 cycles with input pending, then release.
        Out_Ready = 1'b1;
        rand_in();
        In_Valid = 1'b1;
        repeat (S) begin
            @(posedge Clk); #1;
            rand_in();
        end
        Out_Ready = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            check("bp_in_ready", 64'(In_Ready), 64'(0));
            check("bp_out_valid", 64'(Out_Valid), 64'(1));
            @(posedge Clk); #1;
        end
        Out_Ready = 1'b1;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        drain();

        // Random backpressure.
        stream(60, 60);
        drain();

        // Reset mid-stream while stalled.
        Out_Ready = 1'b1;
        rand_in();
        In_Valid = 1'b1;
        repeat (3) begin
            @(posedge Clk); #1;
            rand_in();
        end
        In_Valid  = 1'b0;
        Out_Ready = 1'b0;
        @(posedge Clk); #1;
        check("pre_rst_valid", 64'(Out_Valid), 64'(1));
        #2 Rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(Out_Valid), 64'(0));
        check("midrst_sum", 64'(Sum), 64'(0));
        check("midrst_cout", 64'(Cout), 64'(0));
        check("midrst_in_ready", 64'(In_Ready), 64'(1));
        @(posedge Clk); @(posedge Clk); #3;
        Rst = 1'b0;
        @(posedge Clk); #1;
        Out_Ready = 1'b1;
        repeat (S + 1) begin
            @(posedge Clk); #1;
            check("post_rst_idle", 64'(Out_Valid), 64'(0));
        end

        do_one("post_rst_basic", 8'h3C, 8'h05, 1'b0, 1'b0, 9'h041);
        stream(20, 80);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
